// File: rtl/cpu_clock_controller.sv
// Clock-enable sequencer for the 4-bit CPU: free-run at a selectable rate,
// debounced single-step from a push button, and a sticky halt from the CPU.
module cpu_clock_controller #(
    parameter logic [27:0] DIV0     = 28'd50000000,
    parameter logic [27:0] DIV1     = 28'd5000000,
    parameter logic [27:0] DIV2     = 28'd2500000,
    parameter logic [27:0] DIV3     = 28'd50,
    parameter logic [19:0] DEBOUNCE = 20'd500000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        halt,
    input  logic [1:0]  div_sel,
    output logic        cpu_ce,
    output logic        clk_view,
    output logic [1:0]  state,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  run_sync_reg, run_sync_next;
    logic [2:0]  step_sync_reg, step_sync_next;
    logic [19:0] lockout_reg, lockout_next;
    logic        step_acc_reg, step_acc_next;
    logic [27:0] presc_reg, presc_next;
    logic [27:0] div_q_reg, div_q_next;
    logic [27:0] div_sel_value;
    logic        cpu_ce_reg, ce_next;
    logic        clk_view_reg;
    logic [15:0] cycle_count_reg;
    logic        run_s, step_edge, terminal;

    // Synchroniser chains: stage 0 samples the raw pin, later stages shift.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_run_sync
            if (gi == 0) begin : g_first
                assign run_sync_next[gi] = run_sw;
            end else begin : g_rest
                assign run_sync_next[gi] = run_sync_reg[gi-1];
            end
        end
        for (gi = 0; gi < 3; gi++) begin : g_step_sync
            if (gi == 0) begin : g_first
                assign step_sync_next[gi] = step_btn;
            end else begin : g_rest
                assign step_sync_next[gi] = step_sync_reg[gi-1];
            end
        end
    endgenerate

    assign run_s     = run_sync_reg[1];
    assign step_edge = step_sync_reg[1] & ~step_sync_reg[2];
    assign terminal  = (div_q_reg <= 28'd1) || (presc_reg == div_q_reg - 28'd1);

    always_comb begin
        case (div_sel)
            2'd0:    div_sel_value = DIV0;
            2'd1:    div_sel_value = DIV1;
            2'd2:    div_sel_value = DIV2;
            default: div_sel_value = DIV3;
        endcase
    end

    // Edges are consumed whether or not accepted, so presses never queue.
    always_comb begin
        step_acc_next = step_edge && (lockout_reg == 20'd0);
        lockout_next  = lockout_reg;
        if (step_acc_next) begin
            lockout_next = DEBOUNCE - 20'd1;
        end else if (lockout_reg != 20'd0) begin
            lockout_next = lockout_reg - 20'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        ce_next    = 1'b0;
        presc_next = 28'd0;
        div_q_next = div_q_reg;
        case (state_reg)
            S_IDLE: begin
                div_q_next = div_sel_value;
                if (run_s) begin
                    state_next = S_RUN;
                end else if (step_acc_reg) begin
                    state_next = S_STEP;
                end
            end
            S_RUN: begin
                if (terminal) begin
                    div_q_next = div_sel_value;
                    ce_next    = ~halt;
                end else begin
                    presc_next = presc_reg + 28'd1;
                end
                if (halt) begin
                    state_next = S_HALTED;
                end else if (!run_s) begin
                    state_next = S_IDLE;
                end
            end
            S_STEP: begin
                if (halt) begin
                    state_next = S_HALTED;
                end else begin
                    ce_next    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_HALTED;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            run_sync_reg    <= 2'b00;
            step_sync_reg   <= 3'b000;
            lockout_reg     <= 20'd0;
            step_acc_reg    <= 1'b0;
            presc_reg       <= 28'd0;
            div_q_reg       <= DIV0;
            cpu_ce_reg      <= 1'b0;
            clk_view_reg    <= 1'b0;
            cycle_count_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            run_sync_reg  <= run_sync_next;
            step_sync_reg <= step_sync_next;
            lockout_reg   <= lockout_next;
            step_acc_reg  <= step_acc_next;
            presc_reg     <= presc_next;
            div_q_reg     <= div_q_next;
            cpu_ce_reg    <= ce_next;
            if (ce_next) begin
                clk_view_reg <= ~clk_view_reg;
                if (cycle_count_reg != 16'hFFFF) begin
                    cycle_count_reg <= cycle_count_reg + 16'd1;
                end
            end
        end
    end

    assign cpu_ce      = cpu_ce_reg;
    assign clk_view    = clk_view_reg;
    assign state       = state_reg;
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Randomised bench for cpu_clock_controller: an edge-timed reference model
// schedules expected pulses into a queue that a negedge monitor consumes.
module tb_cpu_clock_controller;

    localparam logic [27:0] P_DIV0 = 28'd4;
    localparam logic [27:0] P_DIV1 = 28'd1;
    localparam logic [27:0] P_DIV2 = 28'd7;
    localparam logic [27:0] P_DIV3 = 28'd0;
    localparam int          P_DEB  = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0, run_sw = 1'b0, step_btn = 1'b0, halt = 1'b0;
    logic [1:0]  div_sel = 2'd0;
    logic        cpu_ce, clk_view;
    logic [1:0]  state;
    logic [15:0] cycle_count;

    cpu_clock_controller #(
        .DIV0(P_DIV0), .DIV1(P_DIV1), .DIV2(P_DIV2), .DIV3(P_DIV3),
        .DEBOUNCE(20'(P_DEB))
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn),
        .halt(halt), .div_sel(div_sel), .cpu_ce(cpu_ce), .clk_view(clk_view),
        .state(state), .cycle_count(cycle_count)
    );

    always #10 clk_in = ~clk_in;

    int checks = 0;
    int passed = 0;

    typedef struct { int edge_no; int count; bit view; } exp_t;
    exp_t exp_q[$];

    // Reference model: inputs seen at edge e reach the FSM at e+2 (run) and
    // e+3 (accepted step request); pulses are scheduled by absolute edge number.
    bit run_hist[4096];
    bit step_hist[4096];
    int cyc = 0, last_rst = 0, lock_free = 0;
    bit acc_pend = 1'b0;
    int mstate = M_IDLE, mnext = 0, mcount = 0, mpulses = 0;
    bit mview = 1'b0;

    function automatic int period(input logic [1:0] s);
        logic [27:0] d;
        case (s)
            2'd0: d = P_DIV0;
            2'd1: d = P_DIV1;
            2'd2: d = P_DIV2;
            default: d = P_DIV3;
        endcase
        return (d <= 28'd1) ? 1 : int'(d);
    endfunction

    always @(posedge clk_in) begin : model
        int e;
        bit rs, ss, sq, acc_seen, acc_now, pulse;
        cyc = cyc + 1;
        e = cyc;
        run_hist[e % 4096]  = run_sw;
        step_hist[e % 4096] = step_btn;
        if (!rst_n) begin
            mstate = M_IDLE; mcount = 0; mview = 1'b0;
            last_rst = e; lock_free = e + 1; acc_pend = 1'b0;
        end else begin
            rs = (e - 2 > last_rst) ? run_hist[(e - 2) % 4096] : 1'b0;
            ss = (e - 2 > last_rst) ? step_hist[(e - 2) % 4096] : 1'b0;
            sq = (e - 3 > last_rst) ? step_hist[(e - 3) % 4096] : 1'b0;
            acc_seen = acc_pend;
            acc_now  = ss && !sq && (e >= lock_free);
            if (acc_now) lock_free = e + P_DEB;
            acc_pend = acc_now;
            pulse = 1'b0;
            case (mstate)
                M_IDLE: begin
                    if (rs) begin
                        mstate = M_RUN;
                        mnext  = e + period(div_sel);
                    end else if (acc_seen) begin
                        mstate = M_STEP;
                    end
                end
                M_RUN: begin
                    if (e == mnext) begin
                        pulse = !halt;
                        mnext = e + period(div_sel);
                    end
                    if (halt) mstate = M_HALTED;
                    else if (!rs) mstate = M_IDLE;
                end
                M_STEP: begin
                    if (halt) mstate = M_HALTED;
                    else begin pulse = 1'b1; mstate = M_IDLE; end
                end
                default: ;
            endcase
            if (pulse) begin
                if (mcount < 65535) mcount = mcount + 1;
                mview = !mview;
                mpulses = mpulses + 1;
                exp_q.push_back('{e, mcount, mview});
            end
        end
    end

    always @(negedge clk_in) begin : monitor
        exp_t it;
        if (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
            it = exp_q.pop_front();
            checks = checks + 1;
            $display("FAIL missed_pulse: no cpu_ce seen, required at edge %0d (now %0d)", it.edge_no, cyc);
        end
        if (cpu_ce === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: cpu_ce=1 at edge %0d, required none", cyc);
            end else begin
                it = exp_q.pop_front();
                if (it.edge_no == cyc && int'(cycle_count) == it.count && clk_view == it.view)
                    passed = passed + 1;
                else
                    $display("FAIL pulse: edge %0d count %0d view %0d, required edge %0d count %0d view %0d",
                             cyc, cycle_count, clk_view, it.edge_no, it.count, it.view);
            end
        end
    end

    task automatic check_eq(input string name, input int act, input int req);
        checks = checks + 1;
        if (act == req) passed = passed + 1;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_state"}, int'(state), mstate);
        check_eq({tag, "_count"}, int'(cycle_count), mcount);
        check_eq({tag, "_view"}, int'(clk_view), int'(mview));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_pulses(input int n);
        int target, t;
        target = mpulses + n;
        t = 0;
        while (mpulses < target && t < 500) begin tick(1); t++; end
    endtask

    task automatic wait_before_pulse();
        int t;
        t = 0;
        while (!(mstate == M_RUN && mnext == cyc + 1) && t < 50) begin tick(1); t++; end
    endtask

    initial begin
        // Reset and plain free-run at rate 0
        do_reset();
        check_outputs("reset");
        check_eq("reset_ce", int'(cpu_ce), 0);
        div_sel = 2'd0; run_sw = 1'b1;
        wait_pulses(10);
        check_outputs("run10");
        check_eq("run10_count_abs", int'(cycle_count), 10);
        run_sw = 1'b0; tick(5);
        check_outputs("run_off");

        // Single-step: long press, short press with bounce, random presses
        step_btn = 1'b1; tick(20); step_btn = 1'b0; tick(3);
        step_btn = 1'b1; tick(1); step_btn = 1'b0; tick(12);
        check_outputs("step_long");
        step_btn = 1'b1; tick(2); step_btn = 1'b0; tick(3);
        step_btn = 1'b1; tick(1); step_btn = 1'b0; tick(14);
        check_outputs("step_bounce");
        for (int i = 0; i < 6; i++) begin
            step_btn = 1'b1; tick($urandom_range(1, 4));
            step_btn = 1'b0; tick($urandom_range(0, 12));
        end
        tick(10);
        check_outputs("step_rand");

        // Rate change mid-period, then every-cycle and random rates
        div_sel = 2'd0; run_sw = 1'b1;
        begin int t = 0; while (mstate != M_RUN && t < 20) begin tick(1); t++; end end
        tick($urandom_range(1, 2));
        div_sel = 2'd2; wait_pulses(3);
        div_sel = 2'd3; wait_pulses(5);
        for (int i = 0; i < 40; i++) begin div_sel = 2'($urandom_range(0, 3)); tick(1); end
        run_sw = 1'b0; tick(6);
        check_outputs("rates");

        // Halt on the terminal-count cycle; HALTED is sticky
        div_sel = 2'd2; run_sw = 1'b1; wait_pulses(2);
        wait_before_pulse();
        halt = 1'b1; tick(1); halt = 1'b0;
        check_outputs("halt");
        for (int i = 0; i < 30; i++) begin
            run_sw = 1'($urandom_range(0, 1)); step_btn = 1'($urandom_range(0, 1)); tick(1);
        end
        run_sw = 1'b0; step_btn = 1'b0; tick(4);
        check_outputs("halt_sticky");
        do_reset();
        check_outputs("halt_reset");

        // Run switch and accepted step reach the FSM together; then reset a pending pulse
        tick(12);
        step_btn = 1'b1; tick(1); run_sw = 1'b1; div_sel = 2'd0; tick(3);
        step_btn = 1'b0; tick(3);
        check_outputs("run_vs_step");
        wait_before_pulse();
        rst_n = 1'b0; tick(1);
        check_eq("abort_ce", int'(cpu_ce), 0);
        check_outputs("abort");
        rst_n = 1'b1; run_sw = 1'b0; tick(3);

        // Saturation
        force dut.cycle_count_reg = 16'hFFFE;
        mcount = 65534;
        tick(1);
        release dut.cycle_count_reg;
        tick(1);
        check_eq("forced", int'(cycle_count), 65534);
        div_sel = 2'd3; run_sw = 1'b1; wait_pulses(3);
        run_sw = 1'b0; tick(6);
        check_outputs("saturate");
        check_eq("saturate_abs", int'(cycle_count), 65535);

        // Random soak
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) run_sw = ~run_sw;
            step_btn = 1'($urandom_range(0, 1));
            div_sel  = 2'($urandom_range(0, 3));
            halt     = ($urandom_range(0, 59) == 0);
            rst_n    = ($urandom_range(0, 79) != 0);
            tick(1);
            if (i % 25 == 24) check_outputs("soak");
        end
        halt = 1'b0; rst_n = 1'b1; run_sw = 1'b0; step_btn = 1'b0;
        tick(20);
        check_outputs("final");
        check_eq("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
